// File: rtl/uart_mem_master_pkg.sv
// uart_mem_master_pkg
//   Shared types and byte constants for the UART memory master:
//   controller state encoding, command opcodes and reply codes.
package uart_mem_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } state_t;

   // Command opcodes (first byte of a frame)
   localparam logic [7:0] CMD_WRITE  = 8'h57;   // 'W' + 4 addr + 4 data
   localparam logic [7:0] CMD_READ   = 8'h52;   // 'R' + 4 addr

   // Reply bytes
   localparam logic [7:0] RSP_OK     = 8'h4B;   // 'K'
   localparam logic [7:0] RSP_ERR    = 8'h45;   // 'E'
   localparam logic [7:0] RSP_BADCMD = 8'h3F;   // '?'

endpackage

// File: rtl/uart_mem_master.sv
// uart_mem_master
//   Parses word read/write commands from a UART receive byte stream, issues
//   one single-word transaction on the data memory bus per command and sends
//   the status/data reply back to a UART transmitter.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_valid_i/rx_data_i  received byte strobe and byte
//   tx_valid_o/tx_data_o  reply byte, held until tx_ready_i
//   tx_ready_i            transmitter accepts the presented byte
//   mem_req_o ...         bus request (one-cycle pulse) with addr/we/be/wdata
//   mem_rvalid_i ...      bus response (err/rdata qualified by rvalid)
//   busy_o                high whenever the controller is not idle
//   overrun_o             sticky flag: byte arrived while not accepting
module uart_mem_master
   import uart_mem_master_pkg::*;
#(
   parameter int RESP_TIMEOUT = 16,
   parameter int BYTE_TIMEOUT = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_ready_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic        mem_err_i,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o,
   output logic        overrun_o
);

   localparam int BTW = $clog2(BYTE_TIMEOUT + 1);
   localparam int RTW = $clog2(RESP_TIMEOUT + 1);

   state_t          state;
   logic            is_write;
   logic [31:0]     addr;
   logic [31:0]     wdata;
   logic [23:0]     reply;       // remaining read-data bytes, next one in [7:0]
   logic [1:0]      byte_cnt;
   logic [1:0]      tx_left;     // bytes still to send after the current one
   logic [BTW-1:0]  byte_timer;
   logic [RTW-1:0]  resp_timer;

   // Fields arrive LSB first: each new byte enters at the top and the
   // previous bytes move down, so after four bytes byte 0 sits in [7:0].
   logic [31:0] next_addr;
   logic [31:0] next_wdata;
   assign next_addr  = {rx_data_i, addr[31:8]};
   assign next_wdata = {rx_data_i, wdata[31:8]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         is_write    <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         reply       <= '0;
         byte_cnt    <= '0;
         tx_left     <= '0;
         byte_timer  <= '0;
         resp_timer  <= '0;
         tx_valid_o  <= 1'b0;
         tx_data_o   <= '0;
         mem_req_o   <= 1'b0;
         mem_addr_o  <= '0;
         mem_we_o    <= 1'b0;
         mem_be_o    <= '0;
         mem_wdata_o <= '0;
         busy_o      <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         mem_req_o <= 1'b0;

         if (rx_valid_i && (state == ST_REQ || state == ST_WAIT || state == ST_RESP))
            overrun_o <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (rx_valid_i) begin
                  busy_o     <= 1'b1;
                  byte_cnt   <= '0;
                  byte_timer <= '0;
                  if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
                     is_write <= (rx_data_i == CMD_WRITE);
                     state    <= ST_ADDR;
                  end else begin
                     tx_valid_o <= 1'b1;
                     tx_data_o  <= RSP_BADCMD;
                     tx_left    <= '0;
                     state      <= ST_RESP;
                  end
               end
            end

            ST_ADDR, ST_DATA: begin
               if (rx_valid_i) begin
                  byte_timer <= '0;
                  byte_cnt   <= byte_cnt + 2'd1;
                  if (state == ST_ADDR)
                     addr <= next_addr;
                  else
                     wdata <= next_wdata;

                  if (byte_cnt == 2'd3) begin
                     if (state == ST_ADDR && is_write) begin
                        state <= ST_DATA;
                     end else begin
                        // Request goes out on the cycle after the last
                        // command byte, so drive it from the byte itself.
                        state      <= ST_REQ;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= ((state == ST_ADDR) ? next_addr : addr) & 32'hFFFF_FFFC;
                        mem_we_o   <= is_write;
                        mem_be_o   <= 4'hF;
                        if (is_write)
                           mem_wdata_o <= next_wdata;
                     end
                  end
               end else if (byte_timer == BTW'(BYTE_TIMEOUT - 1)) begin
                  // Host went quiet mid-frame: drop the partial command.
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end else begin
                  byte_timer <= byte_timer + BTW'(1);
               end
            end

            ST_REQ: begin
               state      <= ST_WAIT;
               resp_timer <= '0;
            end

            ST_WAIT: begin
               if (mem_rvalid_i) begin
                  tx_valid_o <= 1'b1;
                  state      <= ST_RESP;
                  if (mem_err_i) begin
                     tx_data_o <= RSP_ERR;
                     tx_left   <= '0;
                  end else if (is_write) begin
                     tx_data_o <= RSP_OK;
                     tx_left   <= '0;
                  end else begin
                     tx_data_o <= mem_rdata_i[7:0];
                     reply     <= mem_rdata_i[31:8];
                     tx_left   <= 2'd3;
                  end
               end else if (resp_timer == RTW'(RESP_TIMEOUT - 1)) begin
                  tx_valid_o <= 1'b1;
                  tx_data_o  <= RSP_ERR;
                  tx_left    <= '0;
                  state      <= ST_RESP;
               end else begin
                  resp_timer <= resp_timer + RTW'(1);
               end
            end

            ST_RESP: begin
               if (tx_ready_i) begin
                  if (tx_left == 2'd0) begin
                     tx_valid_o <= 1'b0;
                     busy_o     <= 1'b0;
                     state      <= ST_IDLE;
                  end else begin
                     tx_left   <= tx_left - 2'd1;
                     tx_data_o <= reply[7:0];
                     reply     <= {8'h00, reply[23:8]};
                  end
               end
            end

            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mem_master.sv
// tb_uart_mem_master
//   Directed and randomized command frames against uart_mem_master, with a
//   bus responder holding its own memory and a reference word memory built
//   from the commands the bench sends.
module tb_uart_mem_master;
   import uart_mem_master_pkg::*;

   localparam int RT = 16;
   localparam int BT = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_valid_i = 1'b0;
   logic [7:0]  rx_data_i = 8'h00;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        tx_ready_i = 1'b0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i = 1'b0;
   logic        mem_err_i = 1'b0;
   logic [31:0] mem_rdata_i = 32'h0;
   logic        busy_o;
   logic        overrun_o;

   uart_mem_master #(.RESP_TIMEOUT(RT), .BYTE_TIMEOUT(BT)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .overrun_o(overrun_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // ---------------- bus responder (own memory, 0=ok 1=err 2=silent) -------
   int          resp_mode = 0;
   int          req_cnt = 0;
   logic [31:0] bus_mem [logic [31:0]];
   logic        pend = 1'b0;
   logic        pend_err = 1'b0;
   logic [31:0] pend_rdata = 32'h0;

   always @(negedge clk) begin
      mem_rvalid_i = pend;
      mem_err_i    = pend ? pend_err : 1'($urandom);
      mem_rdata_i  = pend ? pend_rdata : $urandom;
      pend = 1'b0;
      if (rst_n && mem_req_o) begin
         req_cnt++;
         if (resp_mode != 2) begin
            pend     = 1'b1;
            pend_err = (resp_mode == 1);
            if (mem_we_o && resp_mode == 0)
               bus_mem[mem_addr_o >> 2] = mem_wdata_o;
            pend_rdata = bus_mem.exists(mem_addr_o >> 2) ? bus_mem[mem_addr_o >> 2] : 32'h0;
         end
      end
   end

   // ---------------- reference model -------------------------------------
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] got;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      @(negedge clk);
      rx_valid_i = 1'b0;
   endtask

   task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d);
      send_byte(wr ? CMD_WRITE : CMD_READ);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
      if (wr) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
   endtask

   // Accept n reply bytes, stalling tx_ready_i for 'stall' cycles on each.
   task automatic collect(input int n, input int stall);
      logic [7:0] b;
      int t;
      got = 32'h0;
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (!tx_valid_o && t < 200) begin
            @(negedge clk);
            t++;
         end
         if (!tx_valid_o) begin
            check("tx_valid_wait", tx_valid_o, 1);
            return;
         end
         b = tx_data_o;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("tx_hold", {tx_valid_o, tx_data_o}, {1'b1, b});
         end
         tx_ready_i = 1'b1;
         @(negedge clk);
         tx_ready_i = 1'b0;
         got[8*i +: 8] = b;
      end
      check("tx_done", tx_valid_o, 0);
   endtask

   task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input int mode, input int stall, input bit poke);
      int req0;
      int n;
      logic [31:0] exp;
      resp_mode = mode;
      req0 = req_cnt;
      send_cmd(wr, a, d);
      check("req_latency", mem_req_o, 1);
      check("req_addr", mem_addr_o, {a[31:2], 2'b00});
      check("req_we", mem_we_o, wr);
      check("req_be", mem_be_o, 4'hF);
      if (wr) check("req_wdata", mem_wdata_o, d);
      @(negedge clk);
      check("resp_early", tx_valid_o, 0);
      @(negedge clk);
      check("resp_latency", tx_valid_o, 1);
      if (poke) begin
         send_byte(8'hA5);
         check("overrun_set", overrun_o, 1);
      end
      if (mode != 0) begin
         exp = {24'h0, RSP_ERR};
         n = 1;
      end else if (wr) begin
         exp = {24'h0, RSP_OK};
         n = 1;
         ref_mem[a >> 2] = d;
      end else begin
         exp = ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
         n = 4;
      end
      collect(n, stall);
      check(wr ? "reply_wr" : "reply_rd", got, exp);
      check("req_count", req_cnt - req0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cycles;
      int req0;
      logic [31:0] a;
      logic [31:0] d;
      bit wr;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_outputs",
            {tx_valid_o, tx_data_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o,
             mem_wdata_o, busy_o, overrun_o}, 96'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write, then preload a word and read it back with a stalled transmitter
      do_txn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 1'b0);
      do_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 0, 1, 1'b0);
      do_txn(1'b0, 32'h0000_0004, 32'h0, 0, 3, 1'b0);

      // Bus error on a write: memory must stay untouched
      do_txn(1'b1, 32'h0000_0008, 32'hCAFE_F00D, 1, 0, 1'b0);
      do_txn(1'b0, 32'h0000_0008, 32'h0, 0, 0, 1'b0);

      // Silent bus: 'E' exactly RESP_TIMEOUT cycles after entering WAIT
      resp_mode = 2;
      send_cmd(1'b0, 32'h0000_0040, 32'h0);
      check("to_req", mem_req_o, 1);
      cycles = 0;
      while (!tx_valid_o && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
      check("timeout_cycles", cycles, RT + 1);
      collect(1, 0);
      check("timeout_reply", got, {24'h0, RSP_ERR});

      // Unknown opcode
      req0 = req_cnt;
      send_byte(8'h00);
      collect(1, 0);
      check("badcmd_reply", got, {24'h0, RSP_BADCMD});
      check("badcmd_noreq", req_cnt, req0);

      // Partial frame then silence: resynchronise without reply or bus access
      send_byte(CMD_READ);
      send_byte(8'h01);
      repeat (BT - 3) @(negedge clk);
      check("resync_busy_before", busy_o, 1);
      repeat (5) @(negedge clk);
      check("resync_busy_after", busy_o, 0);
      check("resync_no_tx", tx_valid_o, 0);
      check("resync_noreq", req_cnt, req0);
      do_txn(1'b0, 32'h0000_1000, 32'h0, 0, 0, 1'b0);

      // Overrun during reply (unaligned read), then sticky across next command
      check("overrun_pre", overrun_o, 0);
      do_txn(1'b0, 32'h0000_0007, 32'h0, 0, 1, 1'b1);
      do_txn(1'b1, 32'h0000_000C, 32'h0BAD_CAFE, 0, 0, 1'b0);
      check("overrun_sticky", overrun_o, 1);

      // Reset while waiting for a response
      resp_mode = 2;
      send_cmd(1'b0, 32'h0000_0080, 32'h0);
      @(negedge clk);
      check("wait_busy", busy_o, 1);
      rst_n = 1'b0;
      #1;
      check("midreset_outputs",
            {tx_valid_o, tx_data_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o,
             mem_wdata_o, busy_o, overrun_o}, 96'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_txn(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 0, 0, 1'b0);
      check("overrun_after_reset", overrun_o, 0);

      // Randomized traffic over a small window of words
      for (int k = 0; k < 30; k++) begin
         wr = 1'($urandom);
         a  = 32'h0000_2000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
         d  = $urandom;
         do_txn(wr, a, d, ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 2), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_mem_master.md
Name: uart_mem_master

Overview:
Byte-stream command engine that acts as a bus initiator on the SoC data memory interface (req/addr/we/be/wdata, rvalid/err/rdata, response exactly one cycle after req). It parses word read/write commands from a UART receive byte stream, issues single-word bus transactions, and returns status/data bytes to a UART transmitter. Used for host-side program loading and memory inspection. It sits beside the core as a second initiator behind an external arbiter.

Parameters:
RESP_TIMEOUT, 16, cycles to wait in WAIT for mem_rvalid_i before reporting an error
BYTE_TIMEOUT, 1_000_000, idle cycles between command bytes before silently resynchronising to IDLE

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rx_valid_i  in  1  one-cycle strobe: rx_data_i holds a received byte
rx_data_i  in  8  received byte
tx_valid_o  out  1  tx_data_o valid; held until tx_ready_i
tx_data_o  out  8  byte to transmit
tx_ready_i  in  1  transmitter accepts byte when tx_valid_o & tx_ready_i
mem_req_o  out  1  bus request, one-cycle pulse
mem_addr_o  out  32  word address, bits [1:0] always 0
mem_we_o  out  1  1 = write
mem_be_o  out  4  byte enables, always 4'hF
mem_wdata_o  out  32  write data
mem_rvalid_i  in  1  response valid
mem_err_i  in  1  response error, qualified by mem_rvalid_i
mem_rdata_i  in  32  read data, qualified by mem_rvalid_i
busy_o  out  1  high in every state except IDLE
overrun_o  out  1  sticky: byte received while not accepting; cleared only by reset

Behaviour:
- Reset: all outputs 0; state IDLE; address/data/counters 0.
- Command frames (multi-byte fields little-endian): 0x57 'W' + 4 addr + 4 data; 0x52 'R' + 4 addr.
- Replies: write OK -> 0x4B 'K'; read OK -> 4 data bytes, LSB first; any bus error/timeout -> 0x45 'E'; unknown opcode -> 0x3F '?'.
- States: IDLE, ADDR, DATA, REQ, WAIT, RESP.
- IDLE: on rx byte 0x57/0x52 latch opcode -> ADDR (byte count 0); other byte -> RESP with '?'.
- ADDR: shift 4 bytes into addr; after 4th -> DATA if write, else REQ. DATA: 4 bytes into wdata -> REQ.
- REQ: mem_req_o=1 for exactly one cycle with addr[31:2],2'b00 / we / be=4'hF / wdata -> WAIT. addr/we/wdata outputs hold their values until the next REQ.
- WAIT: on mem_rvalid_i: err -> reply 'E'; else write -> 'K', read -> latch rdata, 4-byte reply. -> RESP. No rvalid within RESP_TIMEOUT cycles -> 'E' -> RESP. An rvalid arriving outside WAIT is ignored.
- RESP: present byte n of the reply on tx_data_o with tx_valid_o=1; advance on tx_ready_i; after the last byte is accepted -> IDLE. tx_valid_o never drops before acceptance.
- Accepting rx bytes: IDLE, ADDR, DATA only. rx_valid_i in REQ/WAIT/RESP: byte dropped, overrun_o set.
- Byte timeout: a counter in ADDR/DATA resets on each rx byte; reaching BYTE_TIMEOUT -> IDLE, no reply, no bus access.
- Unaligned address: bits [1:0] discarded, no error.
- Minimum latency: last command byte -> mem_req_o next cycle; rvalid -> tx_valid_o next cycle.
- Reset mid-transaction: immediate return to IDLE; any outstanding response is ignored.

Decomposition:
- Package uart_mem_master_pkg: state enum; opcode constants CMD_WRITE=8'h57, CMD_READ=8'h52; reply constants RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_BADCMD=8'h3F.
- Single module. No sub-module: the byte shifters and tx sequencer are small enough to stay inline.

Test Plan:
- Write: rx 57 00 10 00 00 EF BE AD DE, responder rvalid next cycle with err=0 -> one mem_req_o pulse, addr=0x00001000, we=1, be=F, wdata=0xDEADBEEF; tx 4B.
- Read: rx 52 04 00 00 00, rdata=0x12345678 -> req addr=0x00000004, we=0; tx 78 56 34 12 in order, with tx_ready_i stalled 3 cycles per byte and tx_valid_o held throughout.
- Error/timeout: a write answered with err=1 -> tx 45; a read with no rvalid -> tx 45 exactly RESP_TIMEOUT cycles after WAIT entry.
- Bad opcode and resync: rx 0x00 -> tx 3F, no req. rx 52 01, then idle for BYTE_TIMEOUT cycles -> back to IDLE with no tx; a following valid read completes normally.
- Overrun/unaligned: rx byte during RESP -> overrun_o=1, which stays set across the next command. Read addr 0x00000007 -> mem_addr_o=0x00000004.
- Reset: assert rst_n low in WAIT -> all outputs 0 immediately; after release, a 'K' write round-trip succeeds.
